lsu_mem_ctrl: RTL
=================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store initiator between the core's execute stage and the data memory.
//  Accepts one load/store per handshake and drives a req/gnt/rvalid word bus.
//  Generates word address, byte enables and lane-replicated write data.
//  Returns aligned, sign/zero-extended load data; flags misaligned/illegal ops and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in WAIT without mem_rvalid before rsp_err (>=1)
// PORTS
//  cpu_clk       in   1   clock, all logic on posedge
//  cpu_rst       in   1   synchronous active-high reset
//  req_valid     in   1   core request valid
//  req_ready     out  1   block can accept request (IDLE only)
//  req_we        in   1   1 = store, 0 = load
//  req_func3     in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_adr       in   32  byte address
//  req_dataW     in   32  store data (low bits significant for B/H)
//  rsp_valid     out  1   one-cycle completion pulse
//  rsp_dataR     out  32  formatted load data (0 for stores/errors)
//  rsp_misalign  out  1   misaligned or illegal funct3; no bus access made
//  rsp_err       out  1   load timed out on bus
//  mem_req       out  1   bus request, held until mem_gnt
//  mem_gnt       in   1   bus grant
//  mem_we        out  1   bus write
//  mem_adr       out  32  word address {req_adr[31:2],2'b00}
//  mem_be        out  4   byte enables
//  mem_wdata     out  32  lane-replicated store data
//  mem_rvalid    in   1   read data valid
//  mem_rdata     in   32  read word
// BEHAVIOUR
//  Reset: state IDLE; rsp_valid, rsp_misalign, rsp_err, mem_req, mem_we = 0;
//   rsp_dataR, mem_adr, mem_be, mem_wdata = 0; timeout counter = 0; req_ready = 0 while cpu_rst high.
//  Mid-operation reset abandons the transfer; mem_req drops at the reset edge; later rvalid ignored.
//  States: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
//  IDLE: req_ready=1. req_valid&req_ready latches we/func3/adr/dataW.
//   Illegal (store func3 not 000/001/010; load func3 011/110/111) or misaligned (H/HU adr[0]=1;
//   W adr[1:0]!=0) -> RESP with rsp_misalign=1, no mem_req. Else -> ISSUE.
//  ISSUE: mem_req=1; mem_we/adr/be/wdata stable until mem_gnt. On gnt: store -> RESP, load -> WAIT.
//  WAIT: counter increments each cycle; mem_rvalid captures formatted data -> RESP.
//   Counter reaching TIMEOUT_CYCLES without rvalid -> RESP with rsp_err=1, rsp_dataR=0.
//   mem_rvalid arriving in the same cycle as the timeout wins: data is returned, rsp_err=0.
//  RESP: rsp_valid=1 for exactly one cycle; rsp_* hold value until next RESP; -> IDLE.
//  mem_rvalid outside WAIT (incl. same cycle as gnt) is ignored.
//  Store encode: B be=4'b0001<<adr[1:0], wdata={4{d[7:0]}}; H be=4'b0011<<{adr[1],1'b0},
//   wdata={2{d[15:0]}}; W be=4'b1111, wdata=d. Loads drive be=4'b1111, wdata=0.
//  Load format: select byte adr[1:0] / half adr[1]; B,H sign-extend; BU,HU zero-extend; W as-is.
//  Latency (gnt in ISSUE cycle, rvalid first WAIT cycle): load accept->rsp_valid 3 cycles,
//   store 2 cycles, misaligned/illegal 1 cycle. One outstanding transfer max.
// TESTING
//  SB adr=0x103 d=0x000000A5, gnt immediate -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_adr=0x100, rsp_valid 2 cycles after accept.
//  LB adr=0x102, mem_rdata=0x12F45678 -> rsp_dataR=0xFFFFFFF4; LBU same -> 0x000000F4; LHU adr=0x102 -> 0x000012F4.
//  LW adr=0x202 -> rsp_misalign=1, rsp_dataR=0, mem_req never asserted, rsp_valid 1 cycle after accept.
//  gnt withheld 5 cycles -> mem_req and mem_adr/be/wdata stable 5 cycles, req_ready=0 throughout.
//  LW, no rvalid -> rsp_err=1 after TIMEOUT_CYCLES WAIT cycles; late rvalid in IDLE ignored.
//  cpu_rst pulsed in WAIT -> next cycle all outputs 0, then req_ready=1; subsequent SW 0x0 completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: accepts one core request, runs a req/gnt/rvalid word-bus
// transfer, and returns formatted load data with misalign/illegal and timeout flags.
//
// state | meaning
// IDLE  | ready for a request; illegal/misaligned ops go straight to RESP
// ISSUE | mem_req held with stable address/enables/data until mem_gnt
// WAIT  | load granted; waiting for mem_rvalid or timeout
// RESP  | one-cycle rsp_valid pulse
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dataW,
  output logic        rsp_valid,
  output logic [31:0] rsp_dataR,
  output logic        rsp_misalign,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic             accept, bad_op, timeout_hit;
  logic [3:0]       be_enc;
  logic [31:0]      wdata_enc, ld_fmt;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign req_ready   = (state == S_IDLE) && !cpu_rst;
  assign accept      = req_valid && req_ready;
  assign mem_req     = (state == S_ISSUE);
  assign rsp_valid   = (state == S_RESP);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Unsigned variants exist only for loads; stores accept B/H/W.
  always_comb begin
    bad_op = 1'b1;
    case (req_func3)
      3'b000:  bad_op = 1'b0;
      3'b001:  bad_op = req_adr[0];
      3'b010:  bad_op = (req_adr[1:0] != 2'b00);
      3'b100:  bad_op = req_we;
      3'b101:  bad_op = req_we || req_adr[0];
      default: bad_op = 1'b1;
    endcase
  end

  always_comb begin
    be_enc    = 4'b1111;
    wdata_enc = '0;
    if (req_we) begin
      case (req_func3[1:0])
        2'b00: begin
          be_enc    = 4'b0001 << req_adr[1:0];
          wdata_enc = {4{req_dataW[7:0]}};
        end
        2'b01: begin
          be_enc    = 4'b0011 << {req_adr[1], 1'b0};
          wdata_enc = {2{req_dataW[15:0]}};
        end
        default: begin
          be_enc    = 4'b1111;
          wdata_enc = req_dataW;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_fmt = {24'h0, byte_sel};
      3'b101:  ld_fmt = {16'h0, half_sel};
      default: ld_fmt = mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = bad_op ? S_RESP : S_ISSUE;
      S_ISSUE: if (mem_gnt) state_nxt = we_q ? S_RESP : S_WAIT;
      S_WAIT:  if (mem_rvalid || timeout_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      lane_q       <= '0;
      rsp_dataR    <= '0;
      rsp_misalign <= 1'b0;
      rsp_err      <= 1'b0;
      mem_we       <= 1'b0;
      mem_adr      <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (accept) begin
          we_q   <= req_we;
          f3_q   <= req_func3;
          lane_q <= req_adr[1:0];
          cnt    <= '0;
          if (bad_op) begin
            rsp_dataR    <= '0;
            rsp_misalign <= 1'b1;
            rsp_err      <= 1'b0;
          end else begin
            mem_we    <= req_we;
            mem_adr   <= {req_adr[31:2], 2'b00};
            mem_be    <= be_enc;
            mem_wdata <= wdata_enc;
          end
        end
        S_ISSUE: if (mem_gnt && we_q) begin
          rsp_dataR    <= '0;
          rsp_misalign <= 1'b0;
          rsp_err      <= 1'b0;
        end
        // rvalid on the timeout cycle still returns data.
        S_WAIT: begin
          if (mem_rvalid) begin
            rsp_dataR    <= ld_fmt;
            rsp_misalign <= 1'b0;
            rsp_err      <= 1'b0;
          end else if (timeout_hit) begin
            rsp_dataR    <= '0;
            rsp_misalign <= 1'b0;
            rsp_err      <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
